// File: rtl/decoder3to8_strobe.sv
// Sequential 3-to-8 decoder: 3-bit codes arrive over valid/ready and are queued in a FIFO.
// Each queued code is then replayed as a one-hot strobe held for HOLD enabled cycles.
module decoder3to8_strobe #(
    parameter int unsigned HOLD  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] in_code,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] Y,
    output logic       Y_valid,
    output logic       busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic {StIdle, StDrive} state_t;

    state_t          r_state;
    logic   [3:0]    r_cnt;
    logic   [7:0]    r_y;
    logic            r_y_valid;
    logic   [2:0]    r_mem [DEPTH];
    logic   [AW-1:0] r_wptr;
    logic   [AW-1:0] r_rptr;
    logic   [CW-1:0] r_count;

    state_t          w_state_nxt;
    logic   [3:0]    w_cnt_nxt;
    logic   [7:0]    w_y_nxt;
    logic            w_y_valid_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic   [7:0]    w_head_onehot;

    assign in_ready      = (r_count != CW'(DEPTH));
    assign w_empty       = (r_count == '0);
    assign w_push        = in_valid && in_ready;
    // r_count is registered, so a pop only ever sees entries written before this edge.
    assign w_head_onehot = 8'h01 << r_mem[r_rptr];

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_y_nxt       = r_y;
        w_y_valid_nxt = r_y_valid;
        w_pop         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (en && !w_empty) begin
                    w_pop         = 1'b1;
                    w_y_nxt       = w_head_onehot;
                    w_y_valid_nxt = 1'b1;
                    w_cnt_nxt     = 4'(HOLD - 1);
                    w_state_nxt   = StDrive;
                end
            end
            StDrive: begin
                if (en) begin
                    if (r_cnt != 4'd0) begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end else if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_y_nxt       = w_head_onehot;
                        w_y_valid_nxt = 1'b1;
                        w_cnt_nxt     = 4'(HOLD - 1);
                    end else begin
                        w_y_nxt       = 8'h00;
                        w_y_valid_nxt = 1'b0;
                        w_state_nxt   = StIdle;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= 4'd0;
            r_y       <= 8'h00;
            r_y_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_y       <= w_y_nxt;
            r_y_valid <= w_y_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wptr] <= in_code;
        end
    end

    assign Y       = r_y;
    assign Y_valid = r_y_valid;
    assign busy    = (r_state == StDrive) || !w_empty;

endmodule
